lc3_fetch: RTL and testbench
============================

// Module: lc3_fetch
// PURPOSE
//   LC-3 instruction-fetch / PC-update unit. On each fetch_start pulse it drives
//   the current PC onto the memory address bus as a read (wea_out=0), then
//   computes the next PC from the opcode of the instruction just executed:
//   sequential, BR, JMP/RET or JSR. It sits between the control FSM and the
//   instruction memory port.
// PARAMETERS
//   PC_RESET   16'h0000  PC value loaded on reset
//   AW         16        address / PC width (all arithmetic is modulo 2^AW)
// PORTS
//   clk         in   1   single clock; all state changes on its rising edge
//   rst_n       in   1   reset, asynchronous, active-HIGH despite the name
//   fetch_start in   1   one-cycle start pulse; sampled only in IDLE
//   opCode_in   in   4   opcode of the instruction just completed
//   offset_in   in   9   PCoffset9 field (two's complement)
//   reg_in      in   16  BaseR contents, used by JMP/RET
//   br_nzp      in   3   n,z,p mask from the BR instruction [2]=n [1]=z [0]=p
//   result_nzp  in   3   current condition codes, same bit order
//   addr_out    out  16  memory address for the instruction fetch
//   wea_out     out  1   memory write enable; fetch only reads, so held 0
//   pc          out  16  architectural program counter
// BEHAVIOUR
//   Interface (already decided): one clock; reset is asynchronous and
//   active-high. Ports are named clk and rst_n.
//   - Reset (rst_n=1, asynchronous): state=IDLE, pc=PC_RESET, addr_out=0,
//     wea_out=0. All outputs hold these values for as long as rst_n=1.
//   - FSM states: IDLE -> ISSUE -> UPDATE -> IDLE.
//     IDLE:   when fetch_start=1 at a clock edge, go to ISSUE.
//     ISSUE:  register addr_out<=pc and wea_out<=0. Also latch opCode_in,
//             offset_in, reg_in, br_nzp and result_nzp.
//     UPDATE: register pc<=next_pc, then return to IDLE.
//   - fetch_start is ignored in ISSUE and UPDATE. A new fetch may start in the
//     cycle after the FSM returns to IDLE.
//   - Latency: addr_out is valid 1 cycle after fetch_start is sampled. pc is
//     updated 2 cycles after fetch_start is sampled. In the cycle right after
//     fetch_start, pc still shows the old value.
//   - next_pc, with pc1 = pc+1 and off = sign_extend16(offset_in):
//     opcode 0000 BR:    if |(br_nzp & result_nzp) then pc1+off, else pc1.
//                        br_nzp=000 is a never-taken BR.
//     opcode 1100 JMP:   reg_in (RET is JMP with BaseR=R7).
//     opcode 0100 JSR:   pc1+off.
//     any other opcode:  pc1. This includes 1001, 0010 and 1010.
//   - Arithmetic wraps mod 2^16: FFFF+1 = 0000. Negative offsets wrap too.
//   - wea_out is never asserted by this block.
//   - Reset asserted mid-operation aborts immediately to IDLE with reset values.
//     No partial PC update is applied.
//   - Inputs are sampled only at the ISSUE edge. Changes after that have no
//     effect on the fetch in progress.
// TESTING
//   1. Reset held (rst_n=1), pulse fetch_start with opCode_in=1001 ->
//      addr_out=0, wea_out=0, pc=0 every cycle.
//   2. Reset released, pc=0, opCode=0001, fetch_start pulse -> addr_out=0000
//      after 1 cycle. pc stays 0000 on that cycle, then becomes 0001 one cycle
//      later. wea_out=0 throughout.
//   3. pc=0010, BR br_nzp=010, result_nzp=010, offset=9'h1F0 (-16) ->
//      pc=0001. The same case with result_nzp=100 -> pc=0011.
//   4. JMP with reg_in=3000 -> pc=3000. JSR at pc=0005 with offset=0x0FF ->
//      pc=0105.
//   5. pc=FFFF, opCode=0001 -> pc=0000 (wrap).
//   6. fetch_start re-pulsed during ISSUE/UPDATE is ignored (pc advances once).
//      Reset asserted in UPDATE -> pc=PC_RESET and state is IDLE.

Source files
------------

// File: rtl/lc3_fetch.sv
// lc3_fetch: LC-3 instruction fetch / PC update unit.
// Each fetch runs IDLE -> ISSUE -> UPDATE: the address is issued first, then the PC advances.
module lc3_fetch #(
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   PC_RESET = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_start,
    input  logic [3:0]    opCode_in,
    input  logic [8:0]    offset_in,
    input  logic [AW-1:0] reg_in,
    input  logic [2:0]    br_nzp,
    input  logic [2:0]    result_nzp,
    output logic [AW-1:0] addr_out,
    output logic          wea_out,
    output logic [AW-1:0] pc
);
    typedef enum logic [1:0] {IDLE, ISSUE, UPDATE} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, addr_q, reg_q, pc1, off, next_pc;
    logic [3:0]    op_q;
    logic [8:0]    off_q;
    logic [2:0]    br_q, res_q;
    logic          taken;
    always_comb begin
        state_d = state_q == IDLE  ? (fetch_start ? ISSUE : IDLE) :
                  state_q == ISSUE ? UPDATE : IDLE;
        pc1     = pc_q + AW'(1);
        off     = {{(AW-9){off_q[8]}}, off_q};
        taken   = |(br_q & res_q);
        next_pc = op_q == 4'b1100 ? reg_q :
                  (op_q == 4'b0100 || (op_q == 4'b0000 && taken)) ? pc1 + off : pc1;
    end
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    // Instruction fields are captured once at ISSUE so later input changes cannot disturb the update.
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            pc_q   <= PC_RESET;
            addr_q <= '0;
            op_q   <= '0;
            off_q  <= '0;
            reg_q  <= '0;
            br_q   <= '0;
            res_q  <= '0;
        end else begin
            if (state_q == ISSUE) begin
                addr_q <= pc_q;
                op_q   <= opCode_in;
                off_q  <= offset_in;
                reg_q  <= reg_in;
                br_q   <= br_nzp;
                res_q  <= result_nzp;
            end
            if (state_q == UPDATE) pc_q <= next_pc;
        end
    assign addr_out = addr_q;
    assign wea_out  = 1'b0;
    assign pc       = pc_q;
endmodule

// File: tb/tb_lc3_fetch.sv
// tb_lc3_fetch: directed tests for lc3_fetch with hand-computed PC values.
module tb_lc3_fetch;
    logic        clk = 0, rst_n = 1, fetch_start = 0;
    logic [3:0]  opCode_in = 0;
    logic [8:0]  offset_in = 0;
    logic [15:0] reg_in = 0;
    logic [2:0]  br_nzp = 0, result_nzp = 0;
    logic [15:0] addr_out, pc;
    logic        wea_out;
    logic [15:0] cur_pc;
    int          n_tests = 0, n_fail = 0;

    lc3_fetch dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .opCode_in(opCode_in),
        .offset_in(offset_in), .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(result_nzp),
        .addr_out(addr_out), .wea_out(wea_out), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic run_fetch(input logic [3:0] op, input logic [8:0] off, input logic [15:0] rg,
                             input logic [2:0] br, input logic [2:0] res, input logic [15:0] exp,
                             input string name);
        @(negedge clk);
        opCode_in = op; offset_in = off; reg_in = rg; br_nzp = br; result_nzp = res;
        fetch_start = 1;
        @(negedge clk);
        fetch_start = 0;
        n_tests++;
        if (pc !== cur_pc) begin n_fail++; $display("FAIL %s pc_hold1 got %h want %h", name, pc, cur_pc); end
        @(negedge clk);
        n_tests++;
        if (addr_out !== cur_pc) begin n_fail++; $display("FAIL %s addr got %h want %h", name, addr_out, cur_pc); end
        n_tests++;
        if (pc !== cur_pc) begin n_fail++; $display("FAIL %s pc_hold2 got %h want %h", name, pc, cur_pc); end
        n_tests++;
        if (wea_out !== 1'b0) begin n_fail++; $display("FAIL %s wea got %b want 0", name, wea_out); end
        opCode_in = 4'b1100; reg_in = 16'hDEAD; offset_in = ~off; br_nzp = 3'b111; result_nzp = 3'b111;
        @(negedge clk);
        n_tests++;
        if (pc !== exp) begin n_fail++; $display("FAIL %s pc got %h want %h", name, pc, exp); end
        cur_pc = exp;
    endtask

    task automatic test_reset;
        @(negedge clk);
        opCode_in = 4'b1001;
        fetch_start = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fetch_start = 0;
            n_tests++;
            if (addr_out !== 16'h0 || wea_out !== 1'b0 || pc !== 16'h0) begin
                n_fail++;
                $display("FAIL reset cyc%0d got addr=%h wea=%b pc=%h want 0/0/0", i, addr_out, wea_out, pc);
            end
        end
        rst_n = 0;
        cur_pc = 16'h0000;
    endtask

    task automatic test_sequential;
        run_fetch(4'b0001, 9'h000, 16'h0, 3'b000, 3'b000, 16'h0001, "seq");
    endtask

    task automatic test_branch;
        run_fetch(4'b1100, 9'h000, 16'h0010, 3'b000, 3'b000, 16'h0010, "jmp_setup1");
        run_fetch(4'b0000, 9'h1F0, 16'h0, 3'b010, 3'b010, 16'h0001, "br_taken_neg");
        run_fetch(4'b1100, 9'h000, 16'h0010, 3'b000, 3'b000, 16'h0010, "jmp_setup2");
        run_fetch(4'b0000, 9'h1F0, 16'h0, 3'b010, 3'b100, 16'h0011, "br_not_taken");
    endtask

    task automatic test_jmp_jsr;
        run_fetch(4'b1100, 9'h000, 16'h3000, 3'b000, 3'b000, 16'h3000, "jmp");
        run_fetch(4'b1100, 9'h000, 16'h0005, 3'b000, 3'b000, 16'h0005, "jmp_setup3");
        run_fetch(4'b0100, 9'h0FF, 16'h0, 3'b000, 3'b000, 16'h0105, "jsr");
        run_fetch(4'b0000, 9'h0FF, 16'h0, 3'b000, 3'b111, 16'h0106, "br_never");
        run_fetch(4'b1001, 9'h0FF, 16'h0, 3'b111, 3'b111, 16'h0107, "op1001");
        run_fetch(4'b0010, 9'h0FF, 16'h0, 3'b111, 3'b111, 16'h0108, "op0010");
        run_fetch(4'b1010, 9'h0FF, 16'h0, 3'b111, 3'b111, 16'h0109, "op1010");
        run_fetch(4'b0000, 9'h010, 16'h0, 3'b001, 3'b001, 16'h011A, "br_p_pos");
    endtask

    task automatic test_wrap;
        run_fetch(4'b1100, 9'h000, 16'hFFFF, 3'b000, 3'b000, 16'hFFFF, "jmp_ffff");
        run_fetch(4'b0001, 9'h000, 16'h0, 3'b000, 3'b000, 16'h0000, "wrap");
        run_fetch(4'b0100, 9'h1FF, 16'h0, 3'b000, 3'b000, 16'h0000, "jsr_neg_wrap");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        opCode_in = 4'b0001;
        fetch_start = 1;
        repeat (3) @(negedge clk);
        fetch_start = 0;
        n_tests++;
        if (pc !== cur_pc + 16'h1) begin n_fail++; $display("FAIL ignore_step got %h want %h", pc, cur_pc + 16'h1); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (pc !== cur_pc + 16'h1) begin n_fail++; $display("FAIL ignore_once got %h want %h", pc, cur_pc + 16'h1); end
        cur_pc = cur_pc + 16'h1;
    endtask

    task automatic test_reset_mid;
        run_fetch(4'b1100, 9'h000, 16'h4444, 3'b000, 3'b000, 16'h4444, "jmp_setup4");
        @(negedge clk);
        opCode_in = 4'b1100; reg_in = 16'h1234;
        fetch_start = 1;
        @(negedge clk);
        fetch_start = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        n_tests++;
        if (pc !== 16'h0000 || addr_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_async got pc=%h addr=%h want 0000/0000", pc, addr_out);
        end
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        n_tests++;
        if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_hold got %h want 0000", pc); end
        cur_pc = 16'h0000;
        run_fetch(4'b0001, 9'h000, 16'h0, 3'b000, 3'b000, 16'h0001, "after_reset");
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_branch;
        test_jmp_jsr;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
